// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: scanout read port, writer port, clear control
// and the single-port RAM side, grouped so the arbiter sees one bundle.
interface fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, clear_start, mem_rdata,
    output rd_data, rd_valid, wr_ack, clear_busy, clear_done,
           mem_addr, mem_we, mem_wdata
  );

  // Client / RAM side
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, clear_start, mem_rdata,
    input  rd_data, rd_valid, wr_ack, clear_busy, clear_done,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter with a hardware frame-clear sequencer.
// Scanout reads always win, then clear writes, then the drawing writer.
// All RAM-side outputs are registered; reads return after a fixed 3 cycles.
module fb_arbiter #(
  parameter int                ADDR_W      = 17,
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 76800,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fb_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  // DEPTH may equal 2**ADDR_W, so the range compare uses one extra bit
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              grant_rd, grant_clr, grant_wr;
  logic              wr_in_range;
  logic              rd_pipe1, rd_pipe2;

  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_X);

  // Clear FSM state and clear address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Grant selection and next-state; the writer is only served from IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_rd   = 1'b0;
    grant_clr  = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_req)      grant_rd = 1'b1;
        else if (bus.wr_req) grant_wr = 1'b1;
        if (bus.clear_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (bus.rd_req) begin
          grant_rd = 1'b1;
        end else begin
          grant_clr = 1'b1;
          if (cnt == LAST) state_next = DONE;
          else             cnt_next   = cnt + ADDR_W'(1);
        end
      end
      DONE: begin
        if (bus.rd_req) grant_rd = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM command register; address/data hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.wr_ack    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.wr_ack <= grant_wr;
      if (grant_rd) begin
        bus.mem_addr <= bus.rd_addr;
      end else if (grant_clr) begin
        bus.mem_addr  <= cnt;
        bus.mem_wdata <= CLEAR_COLOR;
        bus.mem_we    <= 1'b1;
      end else if (grant_wr) begin
        bus.mem_addr  <= bus.wr_addr;
        bus.mem_wdata <= bus.wr_data;
        bus.mem_we    <= wr_in_range;
      end
    end
  end

  // Read return pipeline: address cycle, RAM output cycle, registered data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe1     <= 1'b0;
      rd_pipe2     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      rd_pipe1     <= grant_rd;
      rd_pipe2     <= rd_pipe1;
      bus.rd_valid <= rd_pipe2;
      if (rd_pipe2) bus.rd_data <= bus.mem_rdata;
    end
  end

  assign bus.clear_busy = (state == CLEAR);
  assign bus.clear_done = (state == DONE);

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer arbiter and clear sequencer for the VGA pipeline. It shares one synchronous-read framebuffer RAM between three users: the VGA scanout pixel fetch, which has absolute priority and fixed latency; a hardware frame-clear sequencer; and the drawing/game-logic writer. It sits between the pixel-timing logic and the framebuffer RAM inside `top`, in the 25 MHz pixel clock domain.

## Interface
Parameters:
- `ADDR_W`, 17: framebuffer address width.
- `DATA_W`, 8: pixel width (RGB332).
- `DEPTH`, 76800: valid addresses are 0..DEPTH-1 (320x240).
- `CLEAR_COLOR`, 8'h00: value written by the clear sequencer.

Ports:
- `clk`  in  1: pixel clock (25 MHz); all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rd_req`  in  1: scanout read request; may be asserted every cycle.
- `rd_addr`  in  ADDR_W: scanout address.
- `rd_data`  out  DATA_W: returned pixel.
- `rd_valid`  out  1: `rd_data` is valid this cycle.
- `wr_req`  in  1: writer request; held until acked.
- `wr_addr`  in  ADDR_W: writer address.
- `wr_data`  in  DATA_W: writer pixel.
- `wr_ack`  out  1: one-cycle pulse; the write was issued.
- `clear_start`  in  1: pulse that starts a full-frame clear.
- `clear_busy`  out  1: the clear is in progress.
- `clear_done`  out  1: one-cycle pulse when the clear completes.
- `mem_addr`  out  ADDR_W: RAM address (registered).
- `mem_we`  out  1: RAM write enable (registered).
- `mem_wdata`  out  DATA_W: RAM write data (registered).
- `mem_rdata`  in  DATA_W: RAM read data, valid the cycle after the RAM samples the address.

## Operation
- Each cycle, grant priority is: scanout read > clear write > writer write. At most one memory operation is issued per cycle.
- **Read path.** When `rd_req=1` in cycle N:
  - `mem_addr=rd_addr`, `mem_we=0` in cycle N+1.
  - `mem_rdata` is valid in cycle N+2.
  - `rd_data` is registered, and `rd_valid=1` in cycle N+3.
  - Reads are never stalled and are fully pipelined: back-to-back requests give back-to-back `rd_valid`.
  - `rd_addr >= DEPTH` is still issued; the returned data is don't-care.
- **Writer.**
  - Master rule: `wr_addr` and `wr_data` stay stable while `wr_req=1` and `wr_ack=0`.
  - Grant condition: in cycle N, `rd_req=0`, the FSM is IDLE and `wr_req=1`. The write appears on `mem_*` in N+1 with `wr_ack=1` in N+1.
  - `wr_req` seen in the ack cycle is treated as a new request.
  - Address >= DEPTH: acked normally, but `mem_we` stays 0 (the write is dropped).
- **Clear FSM.** States are IDLE, CLEAR and DONE.
  - IDLE -> CLEAR on `clear_start=1`. The internal counter is loaded with 0, and `clear_busy=1` from the next cycle.
  - In CLEAR, each cycle with `rd_req=0` issues `mem_we=1`, `mem_addr=cnt`, `mem_wdata=CLEAR_COLOR`, then increments `cnt`. Cycles with `rd_req=1` hold `cnt`.
  - CLEAR -> DONE after the write of `cnt=DEPTH-1` is issued.
  - DONE -> IDLE unconditionally after one cycle. `clear_done=1` and `clear_busy=0` in the DONE cycle.
  - `clear_start` is ignored in CLEAR and DONE.
  - Writer requests are not acked while the FSM is CLEAR or DONE; they are held pending.
- When no grant is made, the next cycle has `mem_we=0`, and `mem_addr`/`mem_wdata` hold their previous values.
- The counter is ADDR_W bits and never exceeds DEPTH-1.

## Timing
- **Reset values:** `mem_addr=0`, `mem_we=0`, `mem_wdata=0`, `rd_data=0`, `rd_valid=0`, `wr_ack=0`, `clear_busy=0`, `clear_done=0`, FSM=IDLE, `cnt=0`.
- **Reset mid-operation:** a reset during CLEAR aborts the clear with no `clear_done`. In-flight reads are discarded, so no `rd_valid` follows reset release.
- **Latencies:**
  - Read request to `rd_valid`: 3 cycles.
  - Write grant to `wr_ack`: 1 cycle.
  - Minimum full clear with no reads: DEPTH cycles from the first clear write, plus 1 DONE cycle.
- **Simultaneous events:**
  - `rd_req` and `wr_req` in the same cycle: the read wins and the write stays pending.
  - `clear_start` and `wr_req` in the same IDLE cycle: the write is granted that cycle, and the clear begins next cycle.
- **Starvation:** the writer may starve while `rd_req` is continuous. This is acceptable, because scanout only requests during the active region.

## Test plan
- Reset with `rst_n=0` for 5 cycles, then release: all outputs are 0, and no `rd_valid` appears before the first `rd_req`.
- Preload RAM[5]=8'hA5. Pulse `rd_req` with `rd_addr=5` at cycle N: `rd_valid=1`, `rd_data=8'hA5` at N+3. Then issue 10 consecutive reads of 0..9: 10 consecutive `rd_valid` cycles with matching data.
- Writer `wr_addr=100`, `wr_data=8'h3C`, with `rd_req` high for 4 cycles: no ack during those 4 cycles, then `wr_ack` 1 cycle after `rd_req` drops. A subsequent read of 100 returns 8'h3C.
- Write to `wr_addr=76800`: `wr_ack` pulses, `mem_we` stays 0, and RAM is unchanged.
- Use DEPTH=16 (overridden) and `clear_start` with no reads: 16 writes to addresses 0..15 on consecutive cycles, then `clear_done` for 1 cycle, with `clear_busy` high throughout. Repeat with `rd_req` every other cycle: completes in 32 cycles and all 16 addresses read back `CLEAR_COLOR`.
- Writer pending during a clear stays unacked until after `clear_done`. Asserting `rst_n=0` at cycle 8 of a clear gives `clear_busy=0` and no `clear_done`.
